// File: rtl/elastic_pipe_reg.sv
// Elastic multi-stage register chain with valid/ready handshakes on both sides.
// Bubbles collapse toward the output; flush synchronously discards all contents.
module elastic_pipe_reg #(
  parameter int                N           = 32,
  parameter int                DEPTH       = 2,
  parameter logic [N-1:0]      RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] go_c;
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer, out_xfer;

  // Advance chain: a stage may move when it is empty or everything ahead of it moves.
  always_comb begin
    go_c = '0;
    go_c[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      go_c[i] = !v_q[i] || go_c[i+1];
    end
  end

  assign in_ready  = go_c[0] && !flush;
  assign out_valid = v_q[DEPTH-1] && !flush;
  assign q         = data_q[DEPTH-1];
  assign count     = count_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next state; data only loads under a valid word so q stays stable across bubbles.
  always_comb begin
    v_d     = v_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush) begin
      v_d     = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VALUE;
      end
    end else begin
      if (go_c[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = d;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (go_c[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised, multi-stage successor to the single flip-flop register.
- Holds N-bit words in a DEPTH-deep chain of registers, using valid/ready handshakes on both sides.
- Empty slots close up automatically (bubble collapse), and a synchronous flush drops everything held.
- Used between Abejaruco pipeline stages where a stage must stall, or must be squashed on a branch or exception.

Parameters:
- N, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VALUE, {N{1'b0}}, value loaded into every data register on reset or flush.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low: 0 resets immediately, regardless of clk.
- flush  input  1  synchronous clear; high = discard all contents at the next edge.
- in_valid  input  1  upstream has a word on d.
- in_ready  output  1  block can accept a word this cycle.
- d  input  N  input word.
- out_valid  output  1  q holds a valid word.
- out_ready  input  1  downstream accepts q this cycle.
- q  output  N  data of the last stage.
- count  output  $clog2(DEPTH+1)  number of valid words held.

Behaviour:
- State: data[0..DEPTH-1] (N bits each) and v[0..DEPTH-1]. Stage 0 is the input end; stage DEPTH-1 drives q.
- Reset (reset=0): takes effect asynchronously.
  - All v=0; all data=RESET_VALUE.
  - Outputs: count=0, out_valid=0, q=RESET_VALUE, in_ready=1 (only if flush=0).
- Reset dominates flush and all handshakes.
- Advance chain (combinational):
  - go[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - go[i] = !v[i] || go[i+1].
  - in_ready = go[0] && !flush.
  - out_valid = v[DEPTH-1] && !flush.
  - A transfer happens when valid && ready on the same cycle.
- Per stage i, when go[i]=1 at an edge:
  - i>0: data[i] <= data[i-1], v[i] <= v[i-1].
  - i=0: data[0] <= d, v[0] <= in_valid.
- When go[i]=0, stage i holds.
- Data registers load only when the incoming valid bit is 1; otherwise the data holds, so q stays stable while out_valid=0.
- Latency:
  - Word accepted at edge t into an empty pipe: out_valid=1 after edge t+DEPTH-1. DEPTH=1 means visible one edge after acceptance.
- Throughput: one word per cycle with out_ready held at 1.
- Bubble collapse: a word advances whenever the next stage is empty, even while out_ready=0.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and nothing moves.
- Full with out_ready=1: in_ready=1 in the same cycle (combinational pass-through). A pop and a push at one edge leave count unchanged.
- count update per edge: +1 on input transfer, -1 on output transfer, both = unchanged. Never exceeds DEPTH; never wraps below 0.
- Flush at an edge (reset=1):
  - All v <= 0; all data <= RESET_VALUE; count <= 0.
  - During the flush cycle in_ready=0 and out_valid=0, so a word presented on d that cycle is dropped and no output transfer occurs.
- in_valid with in_ready=0: the word is not taken. Upstream must hold d and in_valid until in_ready=1.
- out_valid=1 with out_ready=0: q and out_valid stay stable until the transfer.
- No combinational path from in_valid or d to out_valid or q. The only combinational path to in_ready is from out_ready and flush.

Test Plan (N=32, DEPTH=3, RESET_VALUE=0):
1. Reset: hold reset=0 for 2 cycles, then release.
   - Required: count=0, out_valid=0, q=0, in_ready=1.
   - Drive reset=0 mid-cycle while count=2: outputs clear before the next clk edge.
2. Streaming: out_ready=1; push 0x11111111, 0x22222222, 0x33333333 on consecutive edges.
   - Required: out_valid rises 2 edges after the first acceptance.
   - q shows the three words in order on consecutive cycles; count never exceeds 3.
3. Backpressure: out_ready=0; offer 0xA0..0xA3 back-to-back.
   - Required: 0xA0–0xA2 accepted; count=3; in_ready=0; 0xA3 held upstream.
   - Then pulse out_ready=1 for one cycle: in_ready=1 that cycle, q=0xA0 pops, 0xA3 is accepted, count stays 3.
4. Bubble collapse: empty pipe, out_ready=0; push 0xDEADBEEF once.
   - Required: after 2 more edges out_valid=1, q=0xDEADBEEF, count=1, in_ready=1 throughout.
5. Flush: count=2, in_valid=1, d=0xCAFEF00D, flush=1 for one edge.
   - Required: in_ready=0 and out_valid=0 during the flush cycle.
   - Next cycle: count=0, out_valid=0, q=0; 0xCAFEF00D never appears at the output.
6. DEPTH=1 build: push 0x5 with out_ready=0, then 0x6.
   - Required: 0x6 stalls (in_ready=0).
   - On out_ready=1: 0x5 pops and 0x6 is accepted at the same edge.
